// File: rtl/partial_product_generator.sv
// Sequential partial-product source for the shift-add multiplier: one partial
// product per cycle, multiplier LSB first, then a one-cycle gap with a done pulse.
module partial_product_generator #(
    parameter int DATA_WIDTH  = 16,
    parameter int SIGNED_MODE = 1,
    parameter int CNT_WIDTH   = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    input  logic [DATA_WIDTH-1:0] multiplier,
    output logic                  ready,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] partial_product,
    output logic                  partial_product_valid,
    output logic [CNT_WIDTH-1:0]  bit_index,
    output logic                  last,
    output logic                  done,
    output logic                  neg_overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  LAST_IDX = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_pp;
    logic                  r_valid;
    logic [CNT_WIDTH-1:0]  r_idx;
    logic                  r_last;
    logic                  r_done;
    logic                  r_ovf;

    logic [CNT_WIDTH-1:0]  w_next_idx;
    logic                  w_next_msb;
    logic [DATA_WIDTH-1:0] w_run_pp;
    logic                  w_run_ovf;
    logic [DATA_WIDTH-1:0] w_acc_pp;

    // The multiplier's sign bit carries weight -2^(N-1), so its row is negated.
    function automatic logic [DATA_WIDTH-1:0] f_pp(input logic [DATA_WIDTH-1:0] a,
                                                   input logic b_bit,
                                                   input logic msb);
        logic signed [DATA_WIDTH-1:0] w_neg;
        w_neg = -$signed(a);
        if (!b_bit)
            return '0;
        if ((SIGNED_MODE != 0) && msb)
            return w_neg;
        return a;
    endfunction

    function automatic logic f_neg_ovf(input logic [DATA_WIDTH-1:0] a,
                                       input logic b_bit,
                                       input logic msb);
        return (SIGNED_MODE != 0) && b_bit && msb && (a == MIN_NEG);
    endfunction

    assign w_next_idx = r_idx + CNT_WIDTH'(1);
    assign w_next_msb = (w_next_idx == LAST_IDX);
    assign w_run_pp   = f_pp(r_mcand, r_mplier[w_next_idx], w_next_msb);
    assign w_run_ovf  = f_neg_ovf(r_mcand, r_mplier[w_next_idx], w_next_msb);
    // Bit 0 is never the sign row (DATA_WIDTH >= 2), so no overflow on accept.
    assign w_acc_pp   = f_pp(multiplicand, multiplier[0], 1'b0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_pp     <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= multiplicand;
                        r_mplier <= multiplier;
                        r_pp     <= w_acc_pp;
                        r_valid  <= 1'b1;
                        r_idx    <= '0;
                        r_last   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_pp    <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_last) begin
                        r_pp    <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_idx  <= w_next_idx;
                        r_pp   <= w_run_pp;
                        r_last <= w_next_msb;
                        r_ovf  <= r_ovf | w_run_ovf;
                    end
                end
                S_GAP: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready                 = (r_state == S_IDLE);
    assign busy                  = (r_state != S_IDLE);
    assign partial_product       = r_pp;
    assign partial_product_valid = r_valid;
    assign bit_index             = r_idx;
    assign last                  = r_last;
    assign done                  = r_done;
    assign neg_overflow          = r_ovf;

endmodule

// File: tb/tb_partial_product_generator.sv
// Bench for partial_product_generator: signed and unsigned instances share
// stimulus; expected beats are queued on accept and checked as they appear.
module tb_partial_product_generator;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] mcand = '0;
    logic [DW-1:0] mplier = '0;

    logic          ready, busy, valid, last, done, ovf;
    logic [DW-1:0] pp;
    logic [CW-1:0] idx;
    logic          u_ready, u_busy, u_valid, u_last, u_done, u_ovf;
    logic [DW-1:0] u_pp;
    logic [CW-1:0] u_idx;

    partial_product_generator #(.DATA_WIDTH(DW), .SIGNED_MODE(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .multiplicand(mcand), .multiplier(mplier),
        .ready(ready), .busy(busy), .partial_product(pp),
        .partial_product_valid(valid), .bit_index(idx), .last(last),
        .done(done), .neg_overflow(ovf)
    );

    partial_product_generator #(.DATA_WIDTH(DW), .SIGNED_MODE(0)) u_dut_u (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .multiplicand(mcand), .multiplier(mplier),
        .ready(u_ready), .busy(u_busy), .partial_product(u_pp),
        .partial_product_valid(u_valid), .bit_index(u_idx), .last(u_last),
        .done(u_done), .neg_overflow(u_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] pp_s;
        logic [DW-1:0] pp_u;
        logic [CW-1:0] idx;
        logic          last;
        logic          ovf;
    } beat_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] msb_pp;
        logic          ovf;
    } vec_t;

    beat_t sbq[$];
    beat_t mon_e;
    vec_t  vecs[6];
    int    n_tests = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [DW-1:0] msb_pp, input logic ov);
        for (int i = 0; i < DW; i++) begin
            beat_t e;
            e.pp_s = b[i] ? ((i == DW-1) ? msb_pp : a) : '0;
            e.pp_u = b[i] ? a : '0;
            e.idx  = CW'(i);
            e.last = (i == DW-1);
            e.ovf  = (i == DW-1) ? ov : 1'b0;
            sbq.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (reset_n && valid) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got idx %0d expected no beat at %0t", idx, $time);
            end else begin
                mon_e = sbq.pop_front();
                check("pp_signed", 32'(pp), 32'(mon_e.pp_s));
                check("pp_unsigned", 32'(u_pp), 32'(mon_e.pp_u));
                check("bit_index", 32'(idx), 32'(mon_e.idx));
                check("last", 32'(last), 32'(mon_e.last));
                check("neg_overflow", 32'(ovf), 32'(mon_e.ovf));
                check("u_valid", 32'(u_valid), 32'd1);
                check("u_bit_index", 32'(u_idx), 32'(mon_e.idx));
                check("u_last", 32'(u_last), 32'(mon_e.last));
            end
        end
    end

    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] msb_pp, input logic ov, input logic with_abort);
        @(negedge clk);
        #1;
        check("ready_before_accept", 32'(ready), 32'd1);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        abort  = with_abort;
        push_op(a, b, msb_pp, ov);
        @(posedge clk);
        #1;
        start  = 1'b0;
        abort  = 1'b0;
        mcand  = 16'($urandom);
        mplier = 16'($urandom);
    endtask

    // Called 1 time unit after the accept edge.
    task automatic wait_done(input logic ov, input logic abort_gap);
        int k;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #1;
            if (done) begin
                k = c;
                break;
            end
        end
        check("done_latency", 32'(k), 32'd17);
        check("queue_drained", 32'(sbq.size()), 32'd0);
        check("gap_valid", 32'(valid), 32'd0);
        check("gap_pp", 32'(pp), 32'd0);
        check("gap_last", 32'(last), 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        check("gap_ready", 32'(ready), 32'd0);
        check("gap_ovf", 32'(ovf), 32'(ov));
        check("u_done", 32'(u_done), 32'd1);
        check("u_ovf", 32'(u_ovf), 32'd0);
        if (abort_gap) abort = 1'b1;
        @(negedge clk);
        #1;
        abort = 1'b0;
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("u_idle_busy", 32'(u_busy), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'(ov));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int dones;
        vecs[0] = '{a: 16'h0003, b: 16'h0005, msb_pp: 16'h0000, ovf: 1'b0};
        vecs[1] = '{a: 16'h0007, b: 16'hFFFF, msb_pp: 16'hFFF9, ovf: 1'b0};
        vecs[2] = '{a: 16'h8000, b: 16'h8000, msb_pp: 16'h8000, ovf: 1'b1};
        vecs[3] = '{a: 16'h1234, b: 16'h0000, msb_pp: 16'h0000, ovf: 1'b0};
        vecs[4] = '{a: 16'hFFFF, b: 16'h8001, msb_pp: 16'h0001, ovf: 1'b0};
        vecs[5] = '{a: 16'h7FFF, b: 16'hAAAA, msb_pp: 16'h8001, ovf: 1'b0};

        // Reset state
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pp", 32'(pp), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven operations; vector 1 asserts abort with start, vector 2 aborts in GAP.
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].msb_pp, vecs[i].ovf, i == 1);
            wait_done(vecs[i].ovf, i == 2);
        end

        // Abort at bit_index 5 with start held during RUN.
        start_op(16'h00FF, 16'hFFFF, 16'hFF01, 1'b0, 1'b0);
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #1;
            start = 1'b1;
            if (valid && idx == 4'd5) begin
                k = c;
                break;
            end
        end
        check("abort_reached_idx5", 32'(k), 32'd6);
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        sbq.delete();
        @(negedge clk);
        #1;
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_last", 32'(last), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);

        // Asynchronous reset at bit_index 9.
        start_op(16'h0101, 16'hFFFF, 16'hFEFF, 1'b0, 1'b0);
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #1;
            if (valid && idx == 4'd9) begin
                k = c;
                break;
            end
        end
        check("reset_reached_idx9", 32'(k), 32'd10);
        reset_n = 1'b0;
        #1;
        sbq.delete();
        check("async_valid", 32'(valid), 32'd0);
        check("async_pp", 32'(pp), 32'd0);
        check("async_idx", 32'(idx), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(ready), 32'd1);
        check("async_last", 32'(last), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_valid", 32'(valid), 32'd0);
        start_op(16'h0005, 16'h8003, 16'hFFFB, 1'b0, 1'b0);
        wait_done(1'b0, 1'b0);

        // Back-to-back with start held high; second operands applied right after the first accept.
        @(negedge clk);
        #1;
        check("b2b_ready0", 32'(ready), 32'd1);
        mcand  = 16'h0010;
        mplier = 16'h8001;
        start  = 1'b1;
        push_op(16'h0010, 16'h8001, 16'hFFF0, 1'b0);
        @(posedge clk);
        #1;
        mcand  = 16'hFFFE;
        mplier = 16'h8000;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            #1;
            check("b2b_ready", 32'(ready), 32'(c == 18));
            if (c == 18) push_op(16'hFFFE, 16'h8000, 16'h0002, 1'b0);
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        wait_done(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
